mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/core_pkg.sv | 23 ++
 rtl/mem_responder_sram.sv | 38 +++
 rtl/mem_responder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared types and widths for the memory responder and its byte-enabled array.
// No logic, no latency, no backpressure.
package core_pkg;
  localparam int XLEN   = 32;
  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [XLEN-1:0] strb_merge(input logic [XLEN-1:0]   old_w,
                                                 input logic [XLEN-1:0]   new_w,
                                                 input logic [STRB_W-1:0] strb);
    logic [XLEN-1:0] r;
    r = old_w;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction
endpackage

// File: rtl/mem_responder_sram.sv
// Byte-enabled synchronous single-port word array; write or read on an enabled edge.
// Read data is registered one edge after enable; no backpressure, contents never reset.
module mem_responder_sram
  import core_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [STRB_W-1:0] wstrb,
  output logic [XLEN-1:0]   rdata
);
  logic [XLEN-1:0] mem_q [DEPTH_WORDS];
  logic [XLEN-1:0] rdata_q;
  logic [XLEN-1:0] rdata_d;
  logic [XLEN-1:0] wword_d;

  always_comb begin
    rdata_d = mem_q[addr];
    wword_d = strb_merge(mem_q[addr], wdata, wstrb);
  end

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[addr] <= wword_d;
      end else begin
        rdata_q <= rdata_d;
      end
    end
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: IDLE -> WAIT (WAIT_CYCLES) -> RESP; MEM_RESPONDER_ERR_EN adds rsp_err.
// Response first sampled WAIT_CYCLES+1 edges after acceptance; RESP held until rsp_ready, req_ready only in IDLE.
module mem_responder
  import core_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata
`ifdef MEM_RESPONDER_ERR_EN
  ,
  output logic              rsp_err
`endif
);
  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [29:0]         waddr_q, waddr_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;

  logic                sram_go;
  logic [29:0]         cur_waddr;
  logic                cur_we;
  logic [XLEN-1:0]     cur_wdata;
  logic [STRB_W-1:0]   cur_wstrb;
  logic                addr_err;
  logic [XLEN-1:0]     sram_rdata;
  logic                unused_bits;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    sram_go   = 1'b0;
    req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          waddr_d = req_addr[31:2];
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          cnt_d   = 4'd0;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
          end else begin
            state_d = RESP;
            sram_go = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = 4'd0;
          state_d = RESP;
          sram_go = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  // With zero wait the array is driven straight from the request on the accepting edge.
  assign cur_waddr = (state_q == IDLE) ? req_addr[31:2] : waddr_q;
  assign cur_we    = (state_q == IDLE) ? req_we         : we_q;
  assign cur_wdata = (state_q == IDLE) ? req_wdata      : wdata_q;
  assign cur_wstrb = (state_q == IDLE) ? req_wstrb      : wstrb_q;

`ifdef MEM_RESPONDER_ERR_EN
  assign addr_err    = (cur_waddr >> AW) != '0;
  assign rsp_err     = rsp_valid && addr_err;
  assign unused_bits = ^req_addr[1:0];
`else
  assign addr_err    = 1'b0;
  assign unused_bits = ^{req_addr[1:0], cur_waddr[29:AW]};
`endif

  // Gating with rst_n keeps a write abandoned by reset from landing in the array.
  mem_responder_sram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_sram (
    .clk   (clk),
    .en    (sram_go && rst_n && !addr_err),
    .we    (cur_we),
    .addr  (cur_waddr[AW-1:0]),
    .wdata (cur_wdata),
    .wstrb (cur_wstrb),
    .rdata (sram_rdata)
  );

  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = (rsp_valid && !we_q && !addr_err) ? sram_rdata : '0;
endmodule
